fp_from_int: RTL and testbench
==============================

Name: fp_from_int

Overview:
- Sequential integer-to-floating-point converter. Produces N_BIT IEEE-style words in the same field layout and rounding convention the FP add/sub datapath consumes: sign, EXP_BIT exponent, MAN_BIT fraction, round-to-nearest-even, all-ones exponent saturates to INF.
- Accepts one signed or unsigned integer through a valid/ready handshake.
- Normalises with one log-shifter stage per cycle, rounds, then holds the result until the consumer accepts it.
- Sits in front of the FP execution units, serving int-to-float instructions.

Parameters:
- LOG_BIT, 5, log2 of word width.
- EXP_BIT, 8, exponent field width.
- N_BIT, 1<<LOG_BIT, integer and float word width.
- MAN_BIT, N_BIT-EXP_BIT-1, fraction field width. Must be < N_BIT-1.
- BIAS, (1<<(EXP_BIT-1))-1, exponent bias.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  integer operand valid.
- in_ready  out  1  converter can accept an operand.
- in_int  in  N_BIT  integer operand.
- in_signed  in  1  1: in_int is two's complement; 0: in_int is unsigned. Sampled with in_int.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out  out  N_BIT  float result {sign, exp, frac}.
- out_inexact  out  1  result differs from the exact integer value (guard or sticky bit was set).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - Reset (any time, including mid-conversion) forces state=IDLE, out=0, out_inexact=0, out_valid=0, in_ready=1.
  - The in-flight operand is discarded.
- FSM states: IDLE, NORM, ROUND, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready at an edge, register operands and go to NORM with step=LOG_BIT-1.
  - NORM: one shift stage per cycle, shift amount s=1<<step, in order 16,8,4,2,1 for defaults. After the step==0 stage, go to ROUND.
  - ROUND: one cycle. Pack the result, write out/out_inexact, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- in_ready=1 only in IDLE. No new acceptance in the DONE->IDLE cycle.
- Latency: out_valid rises LOG_BIT+1 edges after the accepting edge (6 for defaults). Minimum initiation interval is LOG_BIT+3 cycles.
- Capture:
  - sign = in_signed & in_int[N_BIT-1].
  - mag = sign ? -in_int : in_int, as an N_BIT unsigned value. Signed minimum gives mag=2^(N_BIT-1).
  - exp register = BIAS+N_BIT-1, width EXP_BIT+1.
  - zero flag = (mag==0).
- NORM stage: if mag[N_BIT-1 -: s]==0 then mag <<= s and exp -= s; otherwise no change. Afterwards mag[N_BIT-1]=1 unless zero.
- ROUND:
  - frac = mag[N_BIT-2 -: MAN_BIT].
  - g = mag[N_BIT-2-MAN_BIT].
  - st = |mag[N_BIT-3-MAN_BIT:0].
  - Round up iff g && (frac[0] || st).
  - Fraction carry-out: frac=0, exp+=1.
  - out_inexact = g|st.
  - If exp >= all-ones: out = {sign, all-ones exp, 0 frac} (INF), out_inexact=1.
  - zero: out = all zeros (+0, also for unsigned/signed 0), out_inexact=0.
- Outputs are registered. out and out_inexact hold stable while out_valid && !out_ready, and keep their last value after the handshake until the next ROUND.
- in_int and in_signed are don't-care outside IDLE. Toggling in_valid outside IDLE has no effect.

Test Plan:
- in_int=1, in_signed=1 -> out=0x3F800000, out_inexact=0, out_valid rises exactly 6 edges after acceptance.
- in_int=0xFFFFFFFF: in_signed=1 -> 0xBF800000; in_signed=0 -> 0x4F800000 (round carry into exponent), out_inexact=1.
- in_int=0x80000000, in_signed=1 -> 0xCF000000, out_inexact=0. in_int=0, either signedness -> 0x00000000.
- RNE ties: 16777217 -> 0x4B800000 (tie to even, down); 16777219 -> 0x4B800002 (tie to even, up); 16777221 -> 0x4B800002; all with out_inexact=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out stable, in_ready=0 throughout. Raise out_ready -> out_valid drops next edge, in_ready=1.
- Assert rst_n low during NORM step 2 -> out_valid=0, out=0, in_ready=1 immediately (asynchronous). Next operand (7) converts cleanly to 0x40E00000.

Source files
------------

// File: rtl/fp_from_int.sv
// Sequential int-to-float converter: capture, one log-shifter stage per cycle,
// round-to-nearest-even, then hold the packed result until the consumer takes it.
module fp_from_int #(
  parameter int LOG_BIT = 5,
  parameter int EXP_BIT = 8,
  parameter int N_BIT   = 1 << LOG_BIT,
  parameter int MAN_BIT = N_BIT - EXP_BIT - 1,
  parameter int BIAS    = (1 << (EXP_BIT - 1)) - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_BIT-1:0] in_int,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_BIT-1:0] out,
  output logic             out_inexact
);

  localparam int EW   = EXP_BIT + 1;
  localparam int GPOS = N_BIT - 2 - MAN_BIT;
  // Sticky covers every bit below the guard; empty when the guard is bit 0.
  localparam logic [N_BIT-1:0] ST_MASK = {N_BIT{1'b1}} >> (N_BIT - GPOS);
  localparam logic [EW-1:0]    EXP_MAX = {1'b0, {EXP_BIT{1'b1}}};
  localparam logic [EW-1:0]    EXP_INI = EW'(BIAS + N_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef struct packed {
    logic             sign;
    logic             zero;
    logic [EW-1:0]    expo;
    logic [N_BIT-1:0] mag;
  } op_t;

  logic [1:0]         state;
  logic [LOG_BIT-1:0] step;
  op_t                op, cap;

  logic [LOG_BIT:0]   s;
  logic [N_BIT-1:0]   top_mask, norm_mag;
  logic [EW-1:0]      norm_exp, exp_fin;
  logic               hit;
  logic [MAN_BIT-1:0] frac;
  logic [MAN_BIT:0]   fsum;
  logic               g, st, rnd_up;
  logic [N_BIT-1:0]   pack;
  logic               pack_inx;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    cap.sign = in_signed & in_int[N_BIT-1];
    cap.mag  = cap.sign ? (~in_int + 1'b1) : in_int;
    cap.zero = (in_int == '0);
    cap.expo = EXP_INI;
  end

  // Shift left by s when the top s bits are all zero.
  always_comb begin
    s        = (LOG_BIT+1)'(1) << step;
    top_mask = ~({N_BIT{1'b1}} >> s);
    hit      = |(op.mag & top_mask);
    norm_mag = hit ? op.mag  : (op.mag << s);
    norm_exp = hit ? op.expo : (op.expo - EW'(s));
  end

  always_comb begin
    frac     = op.mag[N_BIT-2 -: MAN_BIT];
    g        = op.mag[GPOS];
    st       = |(op.mag & ST_MASK);
    rnd_up   = g & (frac[0] | st);
    fsum     = {1'b0, frac} + {{MAN_BIT{1'b0}}, rnd_up};
    exp_fin  = op.expo + EW'(fsum[MAN_BIT]);
    pack     = {op.sign, exp_fin[EXP_BIT-1:0], fsum[MAN_BIT-1:0]};
    pack_inx = g | st;
    if (op.zero) begin
      pack     = '0;
      pack_inx = 1'b0;
    end else if (exp_fin >= EXP_MAX) begin
      pack     = {op.sign, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}};
      pack_inx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      step        <= '0;
      op          <= '0;
      out         <= '0;
      out_inexact <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op    <= cap;
          step  <= LOG_BIT'(LOG_BIT - 1);
          state <= NORM;
        end
        NORM: begin
          op.mag  <= norm_mag;
          op.expo <= norm_exp;
          if (step == '0) state <= ROUND;
          else            step  <= step - LOG_BIT'(1);
        end
        ROUND: begin
          out         <= pack;
          out_inexact <= pack_inx;
          state       <= DONE;
        end
        default: if (out_ready) state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_from_int.sv
// Bench for fp_from_int: directed corner cases plus random operands against an
// arithmetic reference (msb search, remainder-vs-half rounding).
module tb_fp_from_int;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_signed;
  logic [31:0] in_int;
  logic        out_valid, out_ready, out_inexact;
  logic [31:0] out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fp_from_int dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_int     (in_int),
    .in_signed  (in_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .out_inexact(out_inexact)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: exact integer -> single precision, RNE, from the magnitude's msb.
  function automatic void model(input logic [31:0] v, input logic sgn_in,
                                output logic [31:0] f, output logic inx);
    logic [63:0] mag, q, rem, half;
    logic        sg;
    int          p, sh;
    sg  = sgn_in & v[31];
    mag = sg ? (64'h1_0000_0000 - {32'b0, v}) : {32'b0, v};
    f = '0; inx = 1'b0;
    if (mag == 0) return;
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin q = q >> 1; p = p + 1; end
    end
    if (127 + p >= 255) begin f = {sg, 8'hFF, 23'd0}; inx = 1'b1; end
    else f = {sg, 8'(127 + p), q[22:0]};
  endfunction

  task automatic send(input logic [31:0] v, input logic sg);
    int w = 0;
    while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
    chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_int = v; in_signed = sg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(input logic [31:0] ef, input logic ex, input int hold, input string tag);
    int edges = 0;
    logic [31:0] held;
    // Noise on the input side must not disturb an in-flight conversion.
    while (!out_valid && edges < 20) begin
      @(posedge clk); #1; edges++;
      if (!out_valid) begin
        in_valid = 1'($urandom); in_int = $urandom; in_signed = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, edges, 6);
    chk({tag, "_out"}, out, ef);
    chk({tag, "_inexact"}, {31'd0, out_inexact}, {31'd0, ex});
    chk({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
    held = out;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_out"}, out, held);
      chk({tag, "_hold_valid"}, {30'd0, out_valid, in_ready}, 32'd2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drop"}, {30'd0, out_valid, in_ready}, 32'd1);
    chk({tag, "_keep_out"}, out, held);
  endtask

  typedef struct { logic [31:0] v; logic sg; logic [31:0] f; logic x; int hold; } dcase_t;
  dcase_t dir[$];

  initial begin
    logic [31:0] v, ef;
    logic        sg, ex;
    rst_n = 1'b0; in_valid = 1'b0; in_int = '0; in_signed = 1'b0; out_ready = 1'b0;
    #12;
    chk("reset_state", {29'd0, out_valid, in_ready, out_inexact}, 32'd2);
    chk("reset_out", out, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    dir.push_back('{32'd1,        1'b1, 32'h3F800000, 1'b0, 0});
    dir.push_back('{32'hFFFFFFFF, 1'b1, 32'hBF800000, 1'b0, 0});
    dir.push_back('{32'hFFFFFFFF, 1'b0, 32'h4F800000, 1'b1, 10});
    dir.push_back('{32'h80000000, 1'b1, 32'hCF000000, 1'b0, 0});
    dir.push_back('{32'd0,        1'b0, 32'h00000000, 1'b0, 1});
    dir.push_back('{32'd0,        1'b1, 32'h00000000, 1'b0, 0});
    dir.push_back('{32'd16777217, 1'b0, 32'h4B800000, 1'b1, 0});
    dir.push_back('{32'd16777219, 1'b1, 32'h4B800002, 1'b1, 2});
    dir.push_back('{32'd16777221, 1'b0, 32'h4B800002, 1'b1, 0});
    foreach (dir[i]) begin
      send(dir[i].v, dir[i].sg);
      collect(dir[i].f, dir[i].x, dir[i].hold, $sformatf("dir%0d", i));
    end

    // Asynchronous reset mid-normalisation, then a clean conversion.
    send(32'h00012345, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_flags", {30'd0, out_valid, in_ready}, 32'd1);
    chk("async_rst_out", out, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    send(32'd7, 1'b1);
    collect(32'h40E00000, 1'b0, 0, "after_rst");

    for (int n = 0; n < 200; n++) begin
      case (n % 3)
        0:       v = $urandom;
        1:       v = $urandom >> $urandom_range(0, 31);
        default: v = 32'($urandom_range(0, 16)) << $urandom_range(0, 28);
      endcase
      sg = 1'($urandom);
      model(v, sg, ef, ex);
      send(v, sg);
      collect(ef, ex, $urandom_range(0, 3), $sformatf("rnd%0d_%08h_%0d", n, v, sg));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
